pci_bus_arbiter: RTL and testbench
==================================

Name: pci_bus_arbiter

Overview:
- Central PCI bus arbiter; shares the single PCI bus among up to N_MASTERS initiator controllers through active-low req/gnt pairs.
- Monitors the shared frame_n/irdy_n lines to track bus ownership, time out masters that are granted but never start, and do hidden arbitration during transactions.
- Parks the bus on a default master when no one requests.

Parameters:
N_MASTERS, 4, number of initiators (2..8)
PARK_MASTER, 0, index granted when no request is pending
TIMEOUT, 16, idle-bus cycles a granted master may wait before asserting frame_n; the grant is then revoked (2..255)

Ports:
clk  input  1  bus clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_n  input  N_MASTERS  per-master request, active low
frame_n  input  1  shared PCI FRAME#, active low
irdy_n  input  1  shared PCI IRDY#, active low
gnt_n  output  N_MASTERS  per-master grant, active low, registered
owner  output  $clog2(N_MASTERS)  index of the currently or most recently granted master
gnt_valid  output  1  high while some gnt_n bit is low
bus_idle  output  1  combinational frame_n & irdy_n

Behaviour:
- Reset (asynchronous, immediate): gnt_n all ones, owner=PARK_MASTER, gnt_valid=0, state=GAP, rr pointer=PARK_MASTER, timeout counter=0, idle_q=1.
- idle_q: register holding the previous cycle's bus_idle.
- start: idle_q=1 and frame_n=0 (first clock of a new transaction).
- At most one gnt_n bit is low in any cycle. Moving the grant between different masters always takes one GAP cycle with all gnt_n high.
- Round-robin winner: the lowest req_n-low index searched cyclically from (rr pointer+1) mod N_MASTERS. If no req_n bit is low, the winner is PARK_MASTER.
- State GAP:
  - gnt_n all ones.
  - Next cycle: go to GRANT with owner=winner (from req_n sampled in GAP), rr pointer=winner, counter cleared.
- State GRANT (gnt_n[owner]=0):
  - start -> BUSY. A transaction is attributed to the granted owner; the arbiter does not check which master drives frame_n.
  - Else if req_n[owner]=1 and any other req_n bit is low -> GAP.
  - Else if req_n[owner]=0 and bus_idle: counter increments. When counter reaches TIMEOUT-1 with no start, go to GAP. The rr pointer already equals owner, so the master is skipped next round.
  - Counter holds while the bus is busy (a previous owner is still finishing) or while the owner is parked (req_n[owner]=1).
  - A parked master with no competing request stays in GRANT indefinitely.
- State BUSY (gnt_n[owner] stays low while no other master requests):
  - Any req_n bit low at an index other than owner -> GAP (hidden arbitration). The current transaction continues; the next owner waits for bus_idle and is detected through start.
  - Otherwise remain in BUSY, even after the transaction ends. A new start while still granted is a back-to-back transaction; stay in BUSY.
  - bus_idle with no other request: remain (implicit park on current owner).
- Simultaneous events:
  - start and timeout in the same cycle: start wins.
  - start and a withdraw/compete condition in GRANT: start wins.
  - req_n changes during GAP are sampled in GAP only.
- Counter is 8 bits, saturating; it never wraps.
- Reset asserted mid-transaction: gnt_n goes high immediately, asynchronously. After release, one GAP cycle, then normal arbitration.

Test Plan:
- Reset/park: rst_n low 3 cycles, release, all req_n=4'hF.
  - gnt_n=4'hF during reset and for exactly 1 cycle after.
  - Then gnt_n=4'hE (master 0 parked), owner=0, and it stays there.
- Single request: req_n=4'b1011.
  - After GAP, gnt_n=4'b1011.
  - Drive frame_n low from an idle bus -> BUSY; gnt_n held through the 3-data-phase transaction.
- Round robin: req_n=4'b0000 held, each master runs a 2-cycle transaction when granted.
  - Grant order 1,2,3,0,1.
  - Exactly one all-ones gnt_n cycle between owners; never two bits low.
- Timeout: req_n=4'b1101, bus idle, frame_n never asserted.
  - gnt_n[1]=0 for exactly 16 cycles, then 1 GAP cycle.
  - Regrant goes to master 1 only if it is the sole requester; otherwise the next requester.
- Hidden arbitration: master 2 in BUSY mid-transaction, master 3 pulls req_n[3] low.
  - gnt_n[2] rises next cycle and gnt_n[3] falls one cycle after.
  - BUSY is re-entered only on the first frame_n fall after frame_n=irdy_n=1.
- Async reset mid-BUSY: pulse rst_n low between clock edges.
  - gnt_n=4'hF without waiting for a clock edge; owner=0.

Source files
------------

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grant over active-low req/gnt pairs,
// with bus parking, grant timeout and hidden arbitration during transactions.
module pci_bus_arbiter #(
    parameter int unsigned N_MASTERS   = 4,
    parameter int unsigned PARK_MASTER = 0,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         req_n,
    input  logic                         frame_n,
    input  logic                         irdy_n,
    output logic [N_MASTERS-1:0]         gnt_n,
    output logic [$clog2(N_MASTERS)-1:0] owner,
    output logic                         gnt_valid,
    output logic                         bus_idle
);

    localparam int unsigned IDX_W = $clog2(N_MASTERS);

    typedef enum logic [1:0] {
        GAP,
        GRANT,
        BUSY
    } state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     owner_d;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]     winner;
    logic [7:0]           cnt, cnt_d;
    logic                 idle_q;
    logic                 start;
    logic                 others_req;
    logic                 timeout_hit;
    logic                 found;
    logic [N_MASTERS-1:0] others_mask;
    logic [N_MASTERS-1:0] gnt_n_d;

    assign bus_idle    = frame_n & irdy_n;
    assign start       = idle_q & ~frame_n;
    assign gnt_valid   = ~&gnt_n;
    assign timeout_hit = (cnt >= 8'(TIMEOUT - 1));

    // Requests from anyone other than the current owner trigger re-arbitration.
    always_comb begin
        others_mask = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            others_mask[i] = (IDX_W'(i) != owner);
        end
        others_req = |(~req_n & others_mask);
    end

    // Cyclic search starting just after the last winner.
    always_comb begin
        winner = IDX_W'(PARK_MASTER);
        found  = 1'b0;
        for (int unsigned i = 1; i <= N_MASTERS; i++) begin
            if (!found && !req_n[IDX_W'((32'(rr_ptr) + i) % N_MASTERS)]) begin
                winner = IDX_W'((32'(rr_ptr) + i) % N_MASTERS);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state;
        owner_d  = owner;
        rr_ptr_d = rr_ptr;
        cnt_d    = cnt;
        case (state)
            GAP: begin
                state_d  = GRANT;
                owner_d  = winner;
                rr_ptr_d = winner;
                cnt_d    = '0;
            end
            GRANT: begin
                if (start) begin
                    state_d = BUSY;
                end else if (req_n[owner] && others_req) begin
                    state_d = GAP;
                end else if (!req_n[owner] && bus_idle) begin
                    if (timeout_hit) begin
                        state_d = GAP;
                    end else if (cnt != '1) begin
                        cnt_d = cnt + 8'd1;
                    end
                end
            end
            BUSY: begin
                if (others_req) begin
                    state_d = GAP;
                end
            end
            default: state_d = GAP;
        endcase

        // Grant register follows the next state so gnt_n never lags the FSM.
        gnt_n_d = '1;
        if (state_d != GAP) begin
            gnt_n_d[owner_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= GAP;
            gnt_n  <= '1;
            owner  <= IDX_W'(PARK_MASTER);
            rr_ptr <= IDX_W'(PARK_MASTER);
            cnt    <= '0;
            idle_q <= 1'b1;
        end else begin
            state  <= state_d;
            gnt_n  <= gnt_n_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
            cnt    <= cnt_d;
            idle_q <= bus_idle;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Self-checking bench for pci_bus_arbiter: vector tables with a scoreboard
// queue, plus hand-written reset sequences and grant-protocol monitors.
module tb_pci_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_n;
    logic       frame_n;
    logic       irdy_n;
    logic [3:0] gnt_n;
    logic [1:0] owner;
    logic       gnt_valid;
    logic       bus_idle;

    always #5 clk = ~clk;

    pci_bus_arbiter #(
        .N_MASTERS  (4),
        .PARK_MASTER(0),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_n    (req_n),
        .frame_n  (frame_n),
        .irdy_n   (irdy_n),
        .gnt_n    (gnt_n),
        .owner    (owner),
        .gnt_valid(gnt_valid),
        .bus_idle (bus_idle)
    );

    typedef struct {
        logic [3:0] req_n;
        logic       frame_n;
        logic       irdy_n;
        logic [3:0] gnt_n;
        logic [1:0] owner;
    } vec_t;

    vec_t        tbl[$];
    vec_t        exp_q[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          ord[5]  = '{1, 2, 3, 0, 1};
    logic [3:0]  prev_gnt = 4'hF;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] gmask(input int m);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << m);
    endfunction

    task automatic push_vec(input logic [3:0] r, input logic f, input logic i,
                            input logic [3:0] g, input logic [1:0] o);
        vec_t v;
        v.req_n   = r;
        v.frame_n = f;
        v.irdy_n  = i;
        v.gnt_n   = g;
        v.owner   = o;
        tbl.push_back(v);
    endtask

    // Called on a falling edge; each record's expectation is checked after the next rising edge.
    task automatic run_table(input string tag);
        vec_t v;
        vec_t e;
        for (int k = 0; k < tbl.size(); k++) begin
            v       = tbl[k];
            req_n   = v.req_n;
            frame_n = v.frame_n;
            irdy_n  = v.irdy_n;
            exp_q.push_back(v);
            #1;
            check($sformatf("%s[%0d].bus_idle", tag, k), 32'(bus_idle), 32'(v.frame_n & v.irdy_n));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d].gnt_n", tag, k), 32'(gnt_n), 32'(e.gnt_n));
            check($sformatf("%s[%0d].owner", tag, k), 32'(owner), 32'(e.owner));
            check($sformatf("%s[%0d].gnt_valid", tag, k), 32'(gnt_valid), 32'(e.gnt_n != 4'hF));
            @(negedge clk);
        end
        tbl.delete();
    endtask

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        req_n   = 4'hF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, ".rst_gnt_n"}, 32'(gnt_n), 32'hF);
        check({tag, ".rst_owner"}, 32'(owner), 32'd0);
        check({tag, ".rst_gnt_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, ".rst_bus_idle"}, 32'(bus_idle), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({tag, ".gap_after_rst"}, 32'(gnt_n), 32'hF);
    endtask

    // Grant protocol: never two grants, never a direct owner-to-owner handoff.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("onehot_gnt", 32'($countones(~gnt_n) > 1), 32'd0);
            check("gap_between_owners",
                  32'((prev_gnt != 4'hF) && (gnt_n != 4'hF) && (prev_gnt != gnt_n)), 32'd0);
        end
        prev_gnt = gnt_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        req_n   = 4'hF;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        @(negedge clk);

        // Reset and park on master 0
        do_reset("park");
        repeat (3) push_vec(4'hF, 1'b1, 1'b1, 4'hE, 2'd0);
        run_table("park");

        // Single requester, 3-data-phase transaction, then back-to-back start
        push_vec(4'b1011, 1'b1, 1'b1, 4'hF, 2'd0);
        push_vec(4'b1011, 1'b1, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b1, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b0, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b0, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b1, 1'b0, 4'hB, 2'd2);
        push_vec(4'hF,    1'b1, 1'b1, 4'hB, 2'd2);
        push_vec(4'hF,    1'b0, 1'b1, 4'hB, 2'd2);
        push_vec(4'hF,    1'b1, 1'b0, 4'hB, 2'd2);
        run_table("single");

        // Round robin with every master requesting
        do_reset("rr");
        push_vec(4'hF,    1'b1, 1'b1, 4'hE, 2'd0);
        push_vec(4'b0000, 1'b1, 1'b1, 4'hE, 2'd0);
        push_vec(4'b0000, 1'b0, 1'b1, 4'hE, 2'd0);
        push_vec(4'b0000, 1'b1, 1'b0, 4'hF, 2'd0);
        for (int m = 0; m < 5; m++) begin
            push_vec(4'b0000, 1'b1, 1'b1, gmask(ord[m]), 2'(ord[m]));
            if (m < 4) begin
                push_vec(4'b0000, 1'b0, 1'b1, gmask(ord[m]), 2'(ord[m]));
                push_vec(4'b0000, 1'b1, 1'b0, 4'hF, 2'(ord[m]));
            end
        end
        run_table("rr");

        // Timeout: 16 granted cycles, one gap, regrant to sole requester, then to the other one
        do_reset("tmo");
        push_vec(4'hF,    1'b1, 1'b1, 4'hE, 2'd0);
        push_vec(4'b1101, 1'b1, 1'b1, 4'hF, 2'd0);
        repeat (16) push_vec(4'b1101, 1'b1, 1'b1, 4'hD, 2'd1);
        push_vec(4'b1101, 1'b1, 1'b1, 4'hF, 2'd1);
        repeat (16) push_vec(4'b1101, 1'b1, 1'b1, 4'hD, 2'd1);
        push_vec(4'b1100, 1'b1, 1'b1, 4'hF, 2'd1);
        push_vec(4'b1100, 1'b1, 1'b1, 4'hE, 2'd0);
        run_table("tmo");

        // Hidden arbitration; busy bus must not advance the timeout
        do_reset("hid");
        push_vec(4'hF,    1'b1, 1'b1, 4'hE, 2'd0);
        push_vec(4'b1011, 1'b1, 1'b1, 4'hF, 2'd0);
        push_vec(4'b1011, 1'b1, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b0, 4'hB, 2'd2);
        push_vec(4'b0011, 1'b0, 1'b0, 4'hF, 2'd2);
        push_vec(4'b0011, 1'b0, 1'b0, 4'h7, 2'd3);
        repeat (18) push_vec(4'b0011, 1'b0, 1'b0, 4'h7, 2'd3);
        push_vec(4'b0011, 1'b1, 1'b0, 4'h7, 2'd3);
        push_vec(4'b0011, 1'b1, 1'b1, 4'h7, 2'd3);
        push_vec(4'b0011, 1'b0, 1'b1, 4'h7, 2'd3);
        push_vec(4'b0011, 1'b0, 1'b0, 4'hF, 2'd3);
        push_vec(4'b1011, 1'b0, 1'b0, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b1, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b1, 4'hB, 2'd2);
        push_vec(4'b1011, 1'b0, 1'b0, 4'hB, 2'd2);
        run_table("hid");

        // Asynchronous reset between clock edges while master 2 is busy
        #2;
        rst_n = 1'b0;
        #1;
        check("async.gnt_n", 32'(gnt_n), 32'hF);
        check("async.owner", 32'(owner), 32'd0);
        check("async.gnt_valid", 32'(gnt_valid), 32'd0);
        @(posedge clk);
        #1;
        check("async.held_gnt_n", 32'(gnt_n), 32'hF);
        @(negedge clk);
        rst_n   = 1'b1;
        req_n   = 4'b0111;
        frame_n = 1'b1;
        irdy_n  = 1'b1;
        #1;
        check("async.gap_after_rst", 32'(gnt_n), 32'hF);
        @(posedge clk);
        #1;
        check("async.regrant_gnt_n", 32'(gnt_n), 32'h7);
        check("async.regrant_owner", 32'(owner), 32'd3);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
